// File: rtl/pe_pkg.sv
// Shared types for the PE feeder: operand width, operand pair, FSM states.
// Pure declarations, no logic.
// Used by the feeder top, its FIFO wrapper and the bus interface.
package pe_pkg;

  localparam int PE_DATA_W = 8;

  typedef logic signed [PE_DATA_W-1:0] data8_t;

  // One FIFO entry: feature in the upper byte, weight in the lower byte.
  typedef struct packed {
    data8_t f;
    data8_t w;
  } pair_t;

  localparam int PAIR_W = $bits(pair_t);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pe_feeder_if.sv
// Bundle of the feeder's control, operand-stream, PE-side and result signals.
// No logic; slave modport is the feeder, master modport is its environment.
// Flow control: in_valid/in_ready for operands, res_valid/res_ready for result.
interface pe_feeder_if import pe_pkg::*; #(
  parameter int LEN_W = 8
);

  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  data8_t           in_f;
  data8_t           in_w;
  data8_t           pe_f;
  data8_t           pe_w;
  logic             pe_enable;
  logic             pe_clear;
  data8_t           pe_psum_next;
  data8_t           pe_out_f;
  data8_t           pe_psum_reg;
  logic             res_valid;
  data8_t           res_data;
  logic             res_ready;

  modport master (
    output start, len, in_valid, in_f, in_w, pe_psum_next, pe_out_f, res_ready,
    input  busy, in_ready, pe_f, pe_w, pe_enable, pe_clear, pe_psum_reg,
           res_valid, res_data
  );

  modport slave (
    input  start, len, in_valid, in_f, in_w, pe_psum_next, pe_out_f, res_ready,
    output busy, in_ready, pe_f, pe_w, pe_enable, pe_clear, pe_psum_reg,
           res_valid, res_data
  );

endinterface

// File: rtl/pe_fifo.sv
// Synchronous FIFO of DEPTH entries x W bits with full/empty flags.
// Latency: a pushed entry is visible at o_dat the cycle after the push.
// Backpressure: pushes while full are dropped (caller gates with !o_full).
module pe_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_dat,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  // Full is judged on registered occupancy only, so a pop never frees a slot
  // for a push in the same cycle.
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_dat   = r_mem[r_rd_ptr];

  // Storage array; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_dat;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pe_feeder.sv
// Feeds buffered operand pairs to an external MAC PE and collects its ReLU result.
// Latency: one MAC per cycle when operands are buffered; result valid 1 cycle after last MAC.
// Backpressure: in_ready = FIFO not full; holds result in DONE until res_ready.
module pe_feeder import pe_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input logic         clk,
  input logic         reset,
  pe_feeder_if.slave  bus
);

  state_t           r_state;
  logic [LEN_W-1:0] r_remaining;
  logic             r_first;
  logic             r_busy;
  logic             r_res_valid;
  data8_t           r_res_data;
  data8_t           r_psum;

  pair_t            w_push_dat;
  pair_t            w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;

  assign w_push_dat = {bus.in_f, bus.in_w};

  pe_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PAIR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (bus.in_valid),
    .i_dat   (w_push_dat),
    .i_pop   (w_pop),
    .o_dat   (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A MAC happens exactly when running and an operand pair is buffered;
  // otherwise the PE sees zero operands with enable low (bubble).
  assign w_pop         = (r_state == ST_RUN) && !w_empty;
  assign bus.in_ready  = !w_full;
  assign bus.pe_enable = w_pop;
  assign bus.pe_clear  = w_pop && r_first;
  assign bus.pe_f      = w_pop ? w_head.f : '0;
  assign bus.pe_w      = w_pop ? w_head.w : '0;

  assign bus.busy        = r_busy;
  assign bus.res_valid   = r_res_valid;
  assign bus.res_data    = r_res_data;
  assign bus.pe_psum_reg = r_psum;

  // Partial-sum register closing the PE loop; the PE itself decides hold vs. update.
  always_ff @(posedge clk) begin
    if (reset) r_psum <= '0;
    else       r_psum <= bus.pe_psum_next;
  end

  // Sequencer: IDLE waits for a non-zero start, RUN counts MACs, DONE holds the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_first     <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start && (bus.len != '0)) begin
            r_remaining <= bus.len;
            r_first     <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_pop) begin
            r_first     <= 1'b0;
            r_remaining <= r_remaining - LEN_W'(1);
            // Last MAC: the PE's combinational ReLU output already reflects it.
            if (r_remaining == LEN_W'(1)) begin
              r_res_data  <= bus.pe_out_f;
              r_res_valid <= 1'b1;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (bus.res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder with a behavioural MAC/ReLU PE in the loop.
// Table-driven vectors for the main dot-product flows, hand sequences for corners.
// Prints one summary line at the end.
module tb_pe_feeder;
  import pe_pkg::*;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  pe_feeder_if #(.LEN_W(8)) bus ();

  pe_feeder #(
    .FIFO_DEPTH (4),
    .LEN_W      (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural PE: signed MAC with saturation, hold when disabled, ReLU output.
  always_comb begin
    int prod;
    int acc;
    int s;
    prod = int'(bus.pe_f) * int'(bus.pe_w);
    acc  = bus.pe_clear ? 0 : int'(bus.pe_psum_reg);
    if (bus.pe_enable) s = acc + prod;
    else               s = int'(bus.pe_psum_reg);
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    bus.pe_psum_next = data8_t'(s);
    bus.pe_out_f     = (s < 0) ? data8_t'(0) : data8_t'(s);
  end

  typedef struct {
    logic st; int ln; logic iv; int f; int w; logic rr;
    logic en; logic clr; int pf; int pw; int psum; logic ird; logic bsy; logic rv; int rd;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic st, input int ln, input logic iv, input int f,
                              input int w, input logic rr, input logic en, input logic clr,
                              input int pf, input int pw, input int psum, input logic ird,
                              input logic bsy, input logic rv, input int rd);
    vec_t v;
    v.st = st; v.ln = ln; v.iv = iv; v.f = f; v.w = w; v.rr = rr;
    v.en = en; v.clr = clr; v.pf = pf; v.pw = pw; v.psum = psum;
    v.ird = ird; v.bsy = bsy; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input int ln, input logic iv, input int f,
                       input int w, input logic rr);
    bus.start     = st;
    bus.len       = 8'(ln);
    bus.in_valid  = iv;
    bus.in_f      = data8_t'(f);
    bus.in_w      = data8_t'(w);
    bus.res_ready = rr;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    drive(1, 3, 1, 9, 9, 0);
    cyc();
    cyc();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_pe_enable", int'(bus.pe_enable), 0);
    chk("rst_psum", int'(bus.pe_psum_reg), 0);
    chk("rst_res_valid", int'(bus.res_valid), 0);
    chk("rst_res_data", int'(bus.res_data), 0);
    cyc();
    chk("rst_busy_after", int'(bus.busy), 0);

    // st ln iv f w rr | en clr pf pw psum ird busy rv rd
    tv.push_back(mk(0,0,1, 2,3,0, 0,0, 0,0,   0,1,0,0,  0));
    tv.push_back(mk(0,0,1, 4,5,0, 0,0, 0,0,   0,1,0,0,  0));
    tv.push_back(mk(0,0,1,-1,6,0, 0,0, 0,0,   0,1,0,0,  0));
    tv.push_back(mk(1,3,0, 0,0,0, 0,0, 0,0,   0,1,0,0,  0));
    tv.push_back(mk(0,0,0, 0,0,0, 1,1, 2,3,   0,1,1,0,  0));
    tv.push_back(mk(0,0,0, 0,0,0, 1,0, 4,5,   6,1,1,0,  0));
    tv.push_back(mk(0,0,0, 0,0,0, 1,0,-1,6,  26,1,1,0,  0));
    tv.push_back(mk(0,0,0, 0,0,1, 0,0, 0,0,  20,1,1,1, 20));
    tv.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,  20,1,0,0, 20));
    tv.push_back(mk(0,0,1,-5,4,0, 0,0, 0,0,  20,1,0,0, 20));
    tv.push_back(mk(1,2,1, 1,1,0, 0,0, 0,0,  20,1,0,0, 20));
    tv.push_back(mk(0,0,0, 0,0,0, 1,1,-5,4,  20,1,1,0, 20));
    tv.push_back(mk(0,0,0, 0,0,0, 1,0, 1,1, -20,1,1,0, 20));
    tv.push_back(mk(0,0,0, 0,0,1, 0,0, 0,0, -19,1,1,1,  0));
    tv.push_back(mk(1,1,1,20,10,0,0,0, 0,0, -19,1,0,0,  0));
    tv.push_back(mk(0,0,0, 0,0,0, 1,1,20,10,-19,1,1,0,  0));
    tv.push_back(mk(0,0,0, 0,0,1, 0,0, 0,0, 127,1,1,1,127));
    tv.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0, 127,1,0,0,127));
    tv.push_back(mk(1,3,1, 2,3,0, 0,0, 0,0, 127,1,0,0,127));
    tv.push_back(mk(0,0,0, 0,0,0, 1,1, 2,3, 127,1,1,0,127));
    tv.push_back(mk(0,0,1, 4,5,0, 0,0, 0,0,   6,1,1,0,127));
    tv.push_back(mk(0,0,0, 0,0,0, 1,0, 4,5,   6,1,1,0,127));
    tv.push_back(mk(0,0,1,-1,6,0, 0,0, 0,0,  26,1,1,0,127));
    tv.push_back(mk(0,0,0, 0,0,0, 1,0,-1,6,  26,1,1,0,127));
    tv.push_back(mk(0,0,0, 0,0,1, 0,0, 0,0,  20,1,1,1, 20));
    tv.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,  20,1,0,0, 20));

    foreach (tv[i]) begin
      drive(tv[i].st, tv[i].ln, tv[i].iv, tv[i].f, tv[i].w, tv[i].rr);
      #1;
      chk($sformatf("v%0d_en", i),    int'(bus.pe_enable),   int'(tv[i].en));
      chk($sformatf("v%0d_clr", i),   int'(bus.pe_clear),    int'(tv[i].clr));
      chk($sformatf("v%0d_pf", i),    int'(bus.pe_f),        tv[i].pf);
      chk($sformatf("v%0d_pw", i),    int'(bus.pe_w),        tv[i].pw);
      chk($sformatf("v%0d_psum", i),  int'(bus.pe_psum_reg), tv[i].psum);
      chk($sformatf("v%0d_ird", i),   int'(bus.in_ready),    int'(tv[i].ird));
      chk($sformatf("v%0d_busy", i),  int'(bus.busy),        int'(tv[i].bsy));
      chk($sformatf("v%0d_rv", i),    int'(bus.res_valid),   int'(tv[i].rv));
      chk($sformatf("v%0d_rd", i),    int'(bus.res_data),    tv[i].rd);
      cyc();
    end

    // Fill the FIFO past capacity: pair k = (10+k, k+1).
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 10 + k, k + 1, 0);
      #1;
      chk($sformatf("full_ird_push%0d", k), int'(bus.in_ready), 1);
      cyc();
    end
    drive(0, 0, 1, 14, 5, 0);
    #1;
    chk("full_ird_held0", int'(bus.in_ready), 0);
    cyc();
    drive(1, 1, 1, 14, 5, 0);
    #1;
    chk("full_ird_held1", int'(bus.in_ready), 0);
    cyc();
    drive(0, 0, 1, 14, 5, 0);
    #1;
    chk("full_pop_en", int'(bus.pe_enable), 1);
    chk("full_pop_pf", int'(bus.pe_f), 10);
    chk("full_ird_nobypass", int'(bus.in_ready), 0);
    cyc();
    #1;
    chk("full_ird_freed", int'(bus.in_ready), 1);
    chk("full_rd1", int'(bus.res_data), 10);
    cyc();
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("full_ird_refull", int'(bus.in_ready), 0);
    cyc();
    drive(1, 4, 0, 0, 0, 0);
    #1;
    chk("full_idle", int'(bus.busy), 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 5; k++) begin
      #1;
      chk($sformatf("full_order_en%0d", k), int'(bus.pe_enable), 1);
      chk($sformatf("full_order_pf%0d", k), int'(bus.pe_f), 10 + k);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("full_rv4", int'(bus.res_valid), 1);
    chk("full_rd4", int'(bus.res_data), 127);
    cyc();

    // DONE holds against start and withheld res_ready.
    drive(1, 1, 1, 3, 3, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("done_pop_pf", int'(bus.pe_f), 3);
    cyc();
    for (int k = 0; k < 3; k++) begin
      drive(1, 2, 1, 1, 1, 0);
      #1;
      chk($sformatf("done_rv%0d", k), int'(bus.res_valid), 1);
      chk($sformatf("done_rd%0d", k), int'(bus.res_data), 9);
      chk($sformatf("done_en%0d", k), int'(bus.pe_enable), 0);
      chk($sformatf("done_busy%0d", k), int'(bus.busy), 1);
      cyc();
    end
    drive(0, 0, 0, 0, 0, 1);
    #1;
    chk("done_rv_release", int'(bus.res_valid), 1);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("done_idle_busy", int'(bus.busy), 0);
    chk("done_idle_rv", int'(bus.res_valid), 0);
    cyc();
    #1;
    chk("done_no_late_start", int'(bus.busy), 0);

    // Reset in the middle of a run, with same-cycle push and start.
    drive(1, 3, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("mid_first_en", int'(bus.pe_enable), 1);
    cyc();
    reset = 1'b1;
    drive(1, 3, 1, 7, 7, 0);
    #1;
    chk("mid_psum_pre", int'(bus.pe_psum_reg), 1);
    cyc();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("mid_busy", int'(bus.busy), 0);
    chk("mid_en", int'(bus.pe_enable), 0);
    chk("mid_clr", int'(bus.pe_clear), 0);
    chk("mid_pf", int'(bus.pe_f), 0);
    chk("mid_pw", int'(bus.pe_w), 0);
    chk("mid_psum", int'(bus.pe_psum_reg), 0);
    chk("mid_rv", int'(bus.res_valid), 0);
    chk("mid_rd", int'(bus.res_data), 0);
    chk("mid_ird", int'(bus.in_ready), 1);
    cyc();
    drive(1, 0, 0, 0, 0, 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("len0_busy", int'(bus.busy), 0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 30 + k, 1, 0);
      #1;
      chk($sformatf("empty_ird%0d", k), int'(bus.in_ready), 1);
      cyc();
    end
    drive(1, 1, 0, 0, 0, 0);
    #1;
    chk("empty_full", int'(bus.in_ready), 0);
    cyc();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("empty_head_pf", int'(bus.pe_f), 30);
    chk("empty_head_clr", int'(bus.pe_clear), 1);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, operand-pair FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter LEN_W, default 8, width of the dot-product length field.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  begin one dot product; sampled only in IDLE.
REQ-007 len  input  LEN_W  number of MACs for the dot product; latched with start.
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 in_valid  input  1  operand pair offered.
REQ-010 in_ready  output  1  FIFO can accept; push = in_valid & in_ready.
REQ-011 in_f / in_w  input  8 each  signed feature / weight.
REQ-012 pe_f / pe_w  output  8 each  operands to PE combinational stage.
REQ-013 pe_enable  output  1  PE MAC enable.
REQ-014 pe_clear  output  1  drives PE reset input (zero accumulator operand).
REQ-015 pe_psum_next  input  8  PE next partial sum.
REQ-016 pe_out_f  input  8  PE ReLU output.
REQ-017 pe_psum_reg  output  8  registered partial sum fed back to PE.
REQ-018 res_valid / res_data / res_ready  out 1 / out 8 / in 1  result handshake.

Function
REQ-019 SHALL register pe_psum_next into pe_psum_reg on every clock edge.
REQ-020 SHALL implement FSM IDLE, RUN, DONE.
REQ-021 IDLE: start & len!=0 -> latch len into remaining counter, set first flag, go RUN; start & len==0 -> ignored, stay IDLE.
REQ-022 RUN, FIFO non-empty: pop head, drive pe_f/pe_w = head, pe_enable=1, pe_clear=first flag, clear first flag, decrement remaining.
REQ-023 RUN, FIFO empty: pe_enable=0, pe_clear=0, pe_f/pe_w=0, counter and psum unchanged (bubble).
REQ-024 On the pop with remaining==1: capture pe_out_f into res_data, go DONE; res_valid high the next cycle.
REQ-025 Back-to-back operation: with FIFO pre-filled, one MAC per cycle; result valid 1 cycle after the last MAC.
REQ-026 DONE: res_valid=1, res_data stable; res_ready=1 -> IDLE next cycle; start ignored.
REQ-027 In IDLE and DONE: pe_enable=0, pe_clear=0, pe_f/pe_w=0.
REQ-028 FIFO SHALL accept pushes in every state; in_ready = !full, no bypass when full even with simultaneous pop.
REQ-029 Pushed entry SHALL become poppable the cycle after the push (no same-cycle bypass into empty FIFO).
REQ-030 Simultaneous push and pop on non-full, non-empty FIFO SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-031 Arithmetic is performed only by the PE; this block SHALL pass operands unmodified and never alter psum.

Reset
REQ-032 reset SHALL force state IDLE, FIFO empty, in_ready=1 the following cycle, pe_psum_reg=0, res_valid=0, res_data=0, busy=0, all pe_* outputs 0, counter 0, first flag 0.
REQ-033 Reset SHALL take priority over every other event, including mid-RUN and same-cycle push/start.

Structure
REQ-034 Shared package pe_pkg SHALL hold PE_DATA_W=8, typedef data8_t (signed 8-bit), and the FSM state enum.
REQ-035 FIFO SHALL be a separate sub-module pe_fifo (synchronous, FIFO_DEPTH x 16 bits, full/empty flags).

Verification
REQ-036 len=3, prefill (2,3),(4,5),(-1,6), start -> pe_enable 3 consecutive cycles, pe_clear on first only, psum 6,26,20, res_data=20.
REQ-037 len=2, pairs (-5,4),(1,1) -> psum -20,-19, res_data=0 (ReLU); pair (20,10) len=1 -> res_data=127 (PE saturation).
REQ-038 Push 5 pairs, no start, FIFO_DEPTH=4 -> in_ready low after 4th push, 5th held until first pop.
REQ-039 len=3, operands arriving every other cycle -> pe_enable low on gaps, pe_psum_reg held, res_data identical to REQ-036.
REQ-040 res_ready low 3 cycles in DONE with start pulsed -> res_data stable, no new RUN; res_ready high -> IDLE next cycle.
REQ-041 reset after 1 of 3 MACs -> all outputs 0 next cycle, FIFO empty, in_ready=1; start len=0 -> busy stays 0.
